// File: rtl/io_oreg_serializer.sv
`default_nettype none
// ============================================================================
// Module   : io_oreg_serializer
// Brief    : Output IO register stage, parallel word in, one bit per CLK out
// Revision : 1.0
// ============================================================================

module io_oreg_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] PDATA,
  input  logic             PVALID,
  output logic             PREADY,
  input  logic             PEN,
  output logic             Q,
  output logic             OE,
  output logic             BUSY
);

  localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_shift = 1'b1;

  logic [0:0]         r_state;
  logic [WIDTH-1:0]   r_shift;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_q;
  logic               r_oe;
  logic               r_busy;

  logic               w_first;
  logic [WIDTH-1:0]   w_load_rest;
  logic               w_next;
  logic [WIDTH-1:0]   w_step;
  logic               w_last;
  logic               w_accept;

  // The shift register only holds the bits not yet driven onto Q.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_first     = PDATA[WIDTH-1];
      assign w_load_rest = PDATA << 1;
      assign w_next      = r_shift[WIDTH-1];
      assign w_step      = r_shift << 1;
    end else begin : g_lsb_first
      assign w_first     = PDATA[0];
      assign w_load_rest = PDATA >> 1;
      assign w_next      = r_shift[0];
      assign w_step      = r_shift >> 1;
    end
  endgenerate

  assign w_last   = (r_cnt == c_last);
  assign PREADY   = !RST && ((r_state == c_st_idle) ||
                             ((r_state == c_st_shift) && w_last));
  assign w_accept = PVALID && PREADY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= c_st_idle;
      r_shift <= '0;
      r_cnt   <= '0;
      r_q     <= 1'b0;
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
    end else if (w_accept) begin
      r_state <= c_st_shift;
      r_shift <= w_load_rest;
      r_cnt   <= '0;
      r_q     <= w_first;
      r_oe    <= PEN;
      r_busy  <= 1'b1;
    end else if (r_state == c_st_shift) begin
      if (!w_last) begin
        r_shift <= w_step;
        r_cnt   <= r_cnt + c_one;
        r_q     <= w_next;
      end else begin
        r_state <= c_st_idle;
        r_shift <= '0;
        r_cnt   <= '0;
        r_q     <= 1'b0;
        r_oe    <= 1'b0;
        r_busy  <= 1'b0;
      end
    end
  end

  assign Q    = r_q;
  assign OE   = r_oe;
  assign BUSY = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_io_oreg_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_oreg_serializer
// Brief    : Directed bench for io_oreg_serializer (MSB/LSB first, WIDTH=1)
// Revision : 1.0
// ============================================================================

module tb_io_oreg_serializer;

  logic CLK;
  logic RST;

  logic [3:0] pdata_a, pdata_b;
  logic [0:0] pdata_c;
  logic pvalid_a, pvalid_b, pvalid_c;
  logic pen_a, pen_b, pen_c;
  logic pready_a, pready_b, pready_c;
  logic q_a, q_b, q_c;
  logic oe_a, oe_b, oe_c;
  logic busy_a, busy_b, busy_c;

  int n_cmp;
  int n_fail;

  io_oreg_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut_a (
    .CLK(CLK), .RST(RST), .PDATA(pdata_a), .PVALID(pvalid_a), .PREADY(pready_a),
    .PEN(pen_a), .Q(q_a), .OE(oe_a), .BUSY(busy_a)
  );

  io_oreg_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut_b (
    .CLK(CLK), .RST(RST), .PDATA(pdata_b), .PVALID(pvalid_b), .PREADY(pready_b),
    .PEN(pen_b), .Q(q_b), .OE(oe_b), .BUSY(busy_b)
  );

  io_oreg_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u_dut_c (
    .CLK(CLK), .RST(RST), .PDATA(pdata_c), .PVALID(pvalid_c), .PREADY(pready_c),
    .PEN(pen_c), .Q(q_c), .OE(oe_c), .BUSY(busy_c)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_b2b;
    logic [3:0] exp_lsb;
    logic [3:0] exp_8;
    n_cmp  = 0;
    n_fail = 0;
    RST = 1'b1;
    pdata_a = '0; pvalid_a = 1'b0; pen_a = 1'b0;
    pdata_b = '0; pvalid_b = 1'b0; pen_b = 1'b0;
    pdata_c = '0; pvalid_c = 1'b0; pen_c = 1'b0;

    // reset state
    #2;
    chk("rst_q",      16'(q_a),      16'h0);
    chk("rst_oe",     16'(oe_a),     16'h0);
    chk("rst_busy",   16'(busy_a),   16'h0);
    chk("rst_pready", 16'(pready_a), 16'h0);
    chk("rst_pready_c", 16'(pready_c), 16'h0);
    tick();
    tick();
    RST = 1'b0;
    #1;
    chk("rel_pready", 16'(pready_a), 16'h1);

    // single word 1011, PEN=1, with an ignored 4'h3 offered mid-word
    pdata_a = 4'b1011; pen_a = 1'b1; pvalid_a = 1'b1;
    tick();
    chk("t1_q1",    16'(q_a),      16'h1);
    chk("t1_oe1",   16'(oe_a),     16'h1);
    chk("t1_busy1", 16'(busy_a),   16'h1);
    chk("t1_rdy1",  16'(pready_a), 16'h0);
    pdata_a = 4'h3; pen_a = 1'b0;
    tick();
    chk("t1_q2",    16'(q_a),      16'h0);
    chk("t1_oe2",   16'(oe_a),     16'h1);
    chk("t1_rdy2",  16'(pready_a), 16'h0);
    tick();
    pvalid_a = 1'b0;
    chk("t1_q3",    16'(q_a),      16'h1);
    chk("t1_busy3", 16'(busy_a),   16'h1);
    tick();
    chk("t1_q4",    16'(q_a),      16'h1);
    chk("t1_oe4",   16'(oe_a),     16'h1);
    chk("t1_rdy4",  16'(pready_a), 16'h1);
    tick();
    chk("t1_q5",    16'(q_a),      16'h0);
    chk("t1_oe5",   16'(oe_a),     16'h0);
    chk("t1_busy5", 16'(busy_a),   16'h0);

    // back-to-back A then 5
    exp_b2b = 8'b1010_0101;
    pdata_a = 4'hA; pen_a = 1'b1; pvalid_a = 1'b1;
    chk("t2_rdy0", 16'(pready_a), 16'h1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("t2_q%0d", i),    16'(q_a),      16'(exp_b2b[7-i]));
      chk($sformatf("t2_oe%0d", i),   16'(oe_a),     16'h1);
      chk($sformatf("t2_busy%0d", i), 16'(busy_a),   16'h1);
      chk($sformatf("t2_rdy%0d", i),  16'(pready_a), 16'((i == 3) || (i == 7)));
      if (i == 3) pdata_a = 4'h5;
    end
    pvalid_a = 1'b0;
    tick();
    chk("t2_end_q",    16'(q_a),    16'h0);
    chk("t2_end_busy", 16'(busy_a), 16'h0);

    // LSB first, PEN=0
    exp_lsb = 4'b1000;
    pdata_b = 4'b0001; pen_b = 1'b0; pvalid_b = 1'b1;
    tick();
    pvalid_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_q%0d", i),    16'(q_b),    16'(exp_lsb[3-i]));
      chk($sformatf("t3_oe%0d", i),   16'(oe_b),   16'h0);
      chk($sformatf("t3_busy%0d", i), 16'(busy_b), 16'h1);
      tick();
    end
    chk("t3_end_busy", 16'(busy_b), 16'h0);

    // async reset during bit 2 of F, then a clean 8
    pdata_a = 4'hF; pen_a = 1'b1; pvalid_a = 1'b1;
    tick();
    pvalid_a = 1'b0;
    tick();
    tick();
    chk("t4_pre_q",    16'(q_a),    16'h1);
    chk("t4_pre_busy", 16'(busy_a), 16'h1);
    #2;
    RST = 1'b1;
    #1;
    chk("t4_rst_q",    16'(q_a),      16'h0);
    chk("t4_rst_oe",   16'(oe_a),     16'h0);
    chk("t4_rst_busy", 16'(busy_a),   16'h0);
    chk("t4_rst_rdy",  16'(pready_a), 16'h0);
    tick();
    RST = 1'b0;
    #1;
    chk("t4_rel_rdy", 16'(pready_a), 16'h1);
    exp_8 = 4'b1000;
    pdata_a = 4'h8; pen_a = 1'b1; pvalid_a = 1'b1;
    tick();
    pvalid_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_q%0d", i),  16'(q_a),  16'(exp_8[3-i]));
      chk($sformatf("t4_oe%0d", i), 16'(oe_a), 16'h1);
      tick();
    end
    chk("t4_end_oe",   16'(oe_a),   16'h0);
    chk("t4_end_busy", 16'(busy_a), 16'h0);

    // WIDTH=1 full-rate stream 1,0,1
    pdata_c = 1'b1; pen_c = 1'b1; pvalid_c = 1'b1;
    chk("t6_rdy0", 16'(pready_c), 16'h1);
    tick();
    chk("t6_q0",   16'(q_c),      16'h1);
    chk("t6_oe0",  16'(oe_c),     16'h1);
    chk("t6_rdy1", 16'(pready_c), 16'h1);
    pdata_c = 1'b0;
    tick();
    chk("t6_q1",   16'(q_c),      16'h0);
    chk("t6_oe1",  16'(oe_c),     16'h1);
    chk("t6_rdy2", 16'(pready_c), 16'h1);
    pdata_c = 1'b1;
    tick();
    chk("t6_q2",   16'(q_c),      16'h1);
    chk("t6_oe2",  16'(oe_c),     16'h1);
    pvalid_c = 1'b0;
    tick();
    chk("t6_end_q",    16'(q_c),      16'h0);
    chk("t6_end_oe",   16'(oe_c),     16'h0);
    chk("t6_end_busy", 16'(busy_c),   16'h0);
    chk("t6_end_rdy",  16'(pready_c), 16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
